// File: rtl/ddr2_controller_ex_prbs_gen_chk_pkg.sv
// Shared types and helpers for the DDR2 example PRBS pattern engine.
// Holds checker state encodings, default taps and the Galois step.
package ddr2_controller_ex_prbs_gen_chk_pkg;

  typedef enum logic {
    ST_HUNT,
    ST_LOCKED
  } state_t;

  localparam logic [7:0]  POLY8  = 8'h1D;
  localparam logic [15:0] POLY16 = 16'h002D;
  localparam logic [31:0] POLY32 = 32'h0000_00C5;

  function automatic logic [63:0] lfsr_step(
    input logic [63:0] x,
    input logic [63:0] poly,
    input int          width
  );
    logic [63:0] n;
    logic        msb;
    msb  = x[6'(width - 1)];
    n    = '0;
    n[0] = msb;
    for (int i = 1; i < 64; i++) begin
      if (i < width) n[i] = x[i-1] ^ (poly[i] & msb);
    end
    return n;
  endfunction

endpackage

// File: rtl/ddr2_controller_ex_prbs_gen_chk_if.sv
// Pattern engine control, data and checker status bundle.
// master drives controls and received words; slave is the engine.
interface ddr2_controller_ex_prbs_gen_chk_if #(
  parameter int WIDTH    = 8,
  parameter int ERRCNT_W = 16
);
  logic                enable;
  logic                mode;
  logic                pause;
  logic                load;
  logic [WIDTH-1:0]    ldata;
  logic [WIDTH-1:0]    data;
  logic                chk_valid;
  logic [WIDTH-1:0]    chk_data;
  logic                clr_err;
  logic                locked;
  logic                error;
  logic [ERRCNT_W-1:0] err_count;

  modport master (
    output enable, mode, pause, load, ldata,
    output chk_valid, chk_data, clr_err,
    input  data, locked, error, err_count
  );

  modport slave (
    input  enable, mode, pause, load, ldata,
    input  chk_valid, chk_data, clr_err,
    output data, locked, error, err_count
  );
endinterface

// File: rtl/ddr2_controller_ex_prbs_gen_chk.sv
// Galois-LFSR pattern generator and self-synchronising checker.
// One instance per lane group; mode picks generate or check.
module ddr2_controller_ex_prbs_gen_chk
  import ddr2_controller_ex_prbs_gen_chk_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] POLY     = 8'h1D,
  parameter int unsigned      SEED     = 32,
  parameter int unsigned      LOCK_CNT = 4,
  parameter int               ERRCNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  ddr2_controller_ex_prbs_gen_chk_if.slave bus
);

  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);
  localparam logic [3:0]       LC_LAST = 4'(LOCK_CNT - 1);

  logic [WIDTH-1:0]    lfsr_q, lfsr_d;
  state_t              st_q, st_d;
  logic [3:0]          mc_q, mc_d;
  logic [3:0]          xc_q, xc_d;
  logic                err_q, err_d;
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;
  logic                mode_q;
  logic                inc;
  logic                match;
  logic [WIDTH-1:0]    s_lfsr, s_chk;

  assign s_lfsr = WIDTH'(lfsr_step(64'(lfsr_q), 64'(POLY), WIDTH));
  assign s_chk  = WIDTH'(lfsr_step(64'(bus.chk_data), 64'(POLY), WIDTH));
  assign match  = (bus.chk_data == lfsr_q);

  always_comb begin
    lfsr_d = lfsr_q;
    st_d   = st_q;
    mc_d   = mc_q;
    xc_d   = xc_q;
    err_d  = 1'b0;
    inc    = 1'b0;
    priority case (1'b1)
      !bus.enable: begin
        if (!bus.mode || !bus.pause || bus.pause) lfsr_d = SEED_V;
        st_d = ST_HUNT;
        mc_d = '0;
        xc_d = '0;
      end
      (bus.mode != mode_q): begin
        st_d = ST_HUNT;
        mc_d = '0;
        xc_d = '0;
      end
      !bus.mode: begin
        if (bus.load)       lfsr_d = bus.ldata;
        else if (!bus.pause) lfsr_d = s_lfsr;
      end
      !bus.chk_valid: ;
      (st_q == ST_HUNT): begin
        lfsr_d = s_chk;
        // zero words never lock, so the register cannot stall at zero
        if (match && (bus.chk_data != '0)) begin
          if (mc_q == LC_LAST) begin
            st_d = ST_LOCKED;
            mc_d = '0;
            xc_d = '0;
          end else begin
            mc_d = mc_q + 4'd1;
          end
        end else begin
          mc_d = '0;
        end
      end
      default: begin
        lfsr_d = s_lfsr;
        if (!match) begin
          err_d = 1'b1;
          inc   = 1'b1;
          if (xc_q == LC_LAST) begin
            st_d = ST_HUNT;
            mc_d = '0;
            xc_d = '0;
          end else begin
            xc_d = xc_q + 4'd1;
          end
        end else begin
          xc_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_err)                cnt_d = '0;
    else if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED_V;
      st_q   <= ST_HUNT;
      mc_q   <= '0;
      xc_q   <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      st_q   <= st_d;
      mc_q   <= mc_d;
      xc_q   <= xc_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      mode_q <= bus.mode;
    end
  end

  assign bus.data      = lfsr_q;
  assign bus.locked    = (st_q == ST_LOCKED);
  assign bus.error     = err_q;
  assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_ddr2_controller_ex_prbs_gen_chk.sv
// Directed and randomized bench for the PRBS pattern engine.
// Expected values come from a behavioural model of the pattern rules.
module tb_ddr2_controller_ex_prbs_gen_chk;

  localparam int W  = 8;
  localparam int EW = 16;
  localparam int LC = 4;

  logic clk;
  logic reset;

  ddr2_controller_ex_prbs_gen_chk_if #(.WIDTH(W), .ERRCNT_W(EW)) bus ();

  ddr2_controller_ex_prbs_gen_chk #(
    .WIDTH(W), .POLY(8'h1D), .SEED(32),
    .LOCK_CNT(LC), .ERRCNT_W(EW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors;
  int miscompares;

  int m_lfsr;
  bit m_hunting;
  int m_match;
  int m_miss;
  bit m_err;
  int m_cnt;
  bit m_mode;

  function automatic int mstep(int x);
    int r;
    r = x * 2;
    if (x >= 128) r = r ^ 'h1D;
    return r % 256;
  endfunction

  task automatic model_reset();
    m_lfsr    = 32;
    m_hunting = 1;
    m_match   = 0;
    m_miss    = 0;
    m_err     = 0;
    m_cnt     = 0;
    m_mode    = 0;
  endtask

  task automatic model_clock();
    bit inc;
    int cd;
    inc   = 0;
    m_err = 0;
    cd    = int'(bus.chk_data);
    if (!bus.enable) begin
      m_lfsr = 32; m_hunting = 1; m_match = 0; m_miss = 0;
    end else if (bus.mode != m_mode) begin
      m_hunting = 1; m_match = 0; m_miss = 0;
    end else if (!bus.mode) begin
      if (bus.load)       m_lfsr = int'(bus.ldata);
      else if (!bus.pause) m_lfsr = mstep(m_lfsr);
    end else if (bus.chk_valid) begin
      if (m_hunting) begin
        if (cd == m_lfsr && cd != 0) m_match++;
        else m_match = 0;
        m_lfsr = mstep(cd);
        if (m_match == LC) begin
          m_hunting = 0; m_match = 0; m_miss = 0;
        end
      end else begin
        if (cd != m_lfsr) begin
          m_err = 1; inc = 1; m_miss++;
        end else begin
          m_miss = 0;
        end
        m_lfsr = mstep(m_lfsr);
        if (m_miss == LC) begin
          m_hunting = 1; m_match = 0; m_miss = 0;
        end
      end
    end
    if (bus.clr_err)           m_cnt = 0;
    else if (inc && m_cnt < 65535) m_cnt++;
    m_mode = bus.mode;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".data"},   64'(bus.data),      64'(m_lfsr));
    chk({tag, ".locked"}, 64'(bus.locked),    64'(!m_hunting && m_mode));
    chk({tag, ".error"},  64'(bus.error),     64'(m_err));
    chk({tag, ".errcnt"}, 64'(bus.err_count), 64'(m_cnt));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_clock();
    #1;
    chk_all(tag);
  endtask

  task automatic send(logic [W-1:0] w, string tag);
    bus.chk_valid = 1'b1;
    bus.chk_data  = w;
    tick(tag);
    bus.chk_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.mode      = 1'b0;
    bus.pause     = 1'b0;
    bus.load      = 1'b0;
    bus.ldata     = '0;
    bus.chk_valid = 1'b0;
    bus.chk_data  = '0;
    bus.clr_err   = 1'b0;
    model_reset();
    #12;
    chk_all("reset");
    chk("reset.seed", 64'(bus.data), 64'h20);
    reset = 1'b0;
    #1;

    bus.enable = 1'b1;
    tick("gen1");
    chk("gen.40", 64'(bus.data), 64'h40);
    tick("gen2");
    chk("gen.80", 64'(bus.data), 64'h80);
    tick("gen3");
    chk("gen.1d", 64'(bus.data), 64'h1D);
    tick("gen4");
    chk("gen.3a", 64'(bus.data), 64'h3A);

    bus.enable = 1'b0;
    tick("gen.rst");
    bus.enable = 1'b1;
    tick("gen.a");
    tick("gen.b");
    bus.pause = 1'b1;
    repeat (3) tick("pause");
    chk("pause.80", 64'(bus.data), 64'h80);
    bus.load  = 1'b1;
    bus.ldata = 8'hA5;
    tick("load");
    chk("load.a5", 64'(bus.data), 64'hA5);
    bus.load  = 1'b0;
    bus.pause = 1'b0;
    tick("after.load");
    chk("load.57", 64'(bus.data), 64'h57);
    bus.enable = 1'b0;
    tick("disable");
    chk("disable.20", 64'(bus.data), 64'h20);

    bus.enable = 1'b1;
    bus.mode   = 1'b1;
    tick("mode.chg");
    send(8'h20, "hunt0");
    send(8'h40, "hunt1");
    send(8'h80, "hunt2");
    send(8'h1D, "hunt3");
    chk("lock.on", 64'(bus.locked), 64'd1);
    send(8'h00, "corrupt");
    chk("corrupt.err", 64'(bus.error), 64'd1);
    chk("corrupt.cnt", 64'(bus.err_count), 64'd1);
    send(8'h74, "resync");
    chk("resync.err", 64'(bus.error), 64'd0);
    chk("resync.lock", 64'(bus.locked), 64'd1);

    bus.clr_err = 1'b1;
    tick("clr");
    bus.clr_err = 1'b0;
    for (int i = 0; i < LC; i++) send(~bus.data, "miss");
    chk("miss.cnt", 64'(bus.err_count), 64'd4);
    chk("miss.unlock", 64'(bus.locked), 64'd0);
    for (int i = 0; i < 8; i++) send(8'h00, "zeros");
    chk("zeros.nolock", 64'(bus.locked), 64'd0);

    send(8'h20, "re0");
    send(8'h40, "re1");
    send(8'h80, "re2");
    send(8'h1D, "re3");
    send(8'h3A, "re4");
    chk("relock", 64'(bus.locked), 64'd1);
    send(8'h00, "err5");
    chk("err5.cnt", 64'(bus.err_count), 64'd5);

    bus.clr_err   = 1'b1;
    bus.chk_valid = 1'b1;
    bus.chk_data  = ~bus.data;
    tick("clr.wins");
    bus.clr_err   = 1'b0;
    bus.chk_valid = 1'b0;
    chk("clr.wins.cnt", 64'(bus.err_count), 64'd0);
    send(8'h00, "pre.rst");

    @(posedge clk);
    model_clock();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk_all("async.rst");
    chk("async.data", 64'(bus.data), 64'h20);
    #3;
    reset = 1'b0;

    for (int n = 0; n < 600; n++) begin
      bus.enable    = ($urandom_range(99) >= 3);
      if ($urandom_range(99) < 3) bus.mode = ~bus.mode;
      bus.pause     = ($urandom_range(99) < 25);
      bus.load      = ($urandom_range(99) < 10);
      bus.ldata     = W'($urandom);
      bus.chk_valid = ($urandom_range(99) < 70);
      bus.clr_err   = ($urandom_range(99) < 3);
      if ($urandom_range(99) < 85) bus.chk_data = W'(m_lfsr);
      else if ($urandom_range(99) < 30) bus.chk_data = '0;
      else bus.chk_data = W'($urandom);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
